// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and
// default bundle widths.
package pipe_pkg;

  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_LANES  = 4;

  // Encoding doubles as the occupancy count driven on Occupancy_Out.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle around one pipeline stage register.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int LANES  = PIPE_LANES
);
  logic                    flush;
  logic                    valid_up;
  logic                    ready_up;
  logic [CTRL_W-1:0]       ctrl_up;
  logic [LANES*DATA_W-1:0] data_up;
  logic                    valid_dn;
  logic                    ready_dn;
  logic [CTRL_W-1:0]       ctrl_dn;
  logic [LANES*DATA_W-1:0] data_dn;
  logic [1:0]              occupancy;

  // master: the environment feeding and draining the stage
  modport master (
    output flush, valid_up, ctrl_up, data_up, ready_dn,
    input  ready_up, valid_dn, ctrl_dn, data_dn, occupancy
  );

  // slave: the stage itself
  modport slave (
    input  flush, valid_up, ctrl_up, data_up, ready_dn,
    output ready_up, valid_dn, ctrl_dn, data_dn, occupancy
  );
endinterface

// File: rtl/pipe_slot.sv
// One entry register (control + data) with load enable and synchronous clear.
module pipe_slot #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake; SKID=1 adds a second
// slot so Ready_Out comes straight from a register.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int LANES  = PIPE_LANES,
  parameter int SKID   = 1
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    Flush_In,
  input  logic                    Valid_In,
  output logic                    Ready_Out,
  input  logic [CTRL_W-1:0]       Ctrl_In,
  input  logic [LANES*DATA_W-1:0] Data_In,
  output logic                    Valid_Out,
  input  logic                    Ready_In,
  output logic [CTRL_W-1:0]       Ctrl_Out,
  output logic [LANES*DATA_W-1:0] Data_Out,
  output logic [1:0]              Occupancy_Out
);
  localparam int PAY_W  = LANES * DATA_W;
  localparam int SLOT_W = CTRL_W + PAY_W;

  pipe_state_e       state_reg;
  pipe_state_e       state_next;
  logic [SLOT_W-1:0] main_q;
  logic [SLOT_W-1:0] main_d;
  logic              main_load;
  logic              valid;
  logic              accept;
  logic              deliver;

  assign valid   = (state_reg != ST_EMPTY);
  assign accept  = Valid_In && Ready_Out;
  assign deliver = valid && Ready_In;

  generate
    if (SKID != 0) begin : g_skid
      logic [SLOT_W-1:0] skid_q;
      logic              skid_load;

      // Registered ready: no path from Ready_In to Ready_Out.
      assign Ready_Out = (state_reg != ST_TWO);

      always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = {Ctrl_In, Data_In};
        case (state_reg)
          ST_EMPTY: begin
            if (accept) begin
              state_next = ST_ONE;
              main_load  = 1'b1;
            end
          end
          ST_ONE: begin
            if (accept && deliver) begin
              main_load = 1'b1;
            end else if (accept) begin
              state_next = ST_TWO;
              skid_load  = 1'b1;
            end else if (deliver) begin
              state_next = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (deliver) begin
              state_next = ST_ONE;
              main_load  = 1'b1;
              main_d     = skid_q;
            end
          end
          default: state_next = ST_EMPTY;
        endcase
        // Flush wins over everything except reset; offered entry is dropped.
        if (Flush_In) begin
          state_next = ST_EMPTY;
          main_load  = 1'b0;
          skid_load  = 1'b0;
        end
      end

      pipe_slot #(.W(SLOT_W)) u_skid_slot (
        .clk  (CLOCK),
        .srst (RESET),
        .load (skid_load),
        .d    ({Ctrl_In, Data_In}),
        .q    (skid_q)
      );
    end else begin : g_single
      assign Ready_Out = !valid || Ready_In;

      always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        main_d     = {Ctrl_In, Data_In};
        case (state_reg)
          ST_EMPTY: begin
            if (accept) begin
              state_next = ST_ONE;
              main_load  = 1'b1;
            end
          end
          ST_ONE: begin
            if (accept) begin
              main_load = 1'b1;
            end else if (deliver) begin
              state_next = ST_EMPTY;
            end
          end
          default: state_next = ST_EMPTY;
        endcase
        if (Flush_In) begin
          state_next = ST_EMPTY;
          main_load  = 1'b0;
        end
      end
    end
  endgenerate

  pipe_slot #(.W(SLOT_W)) u_main_slot (
    .clk  (CLOCK),
    .srst (RESET),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  assign Valid_Out     = valid;
  assign Occupancy_Out = state_reg;
  // Bubbles carry an all-zero control word so no downstream enable fires.
  assign Ctrl_Out      = valid ? main_q[SLOT_W-1 -: CTRL_W] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign Data_Out[gi*DATA_W +: DATA_W] = main_q[gi*DATA_W +: DATA_W];
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks of pipe_stage_reg in skid (SKID=1) and single-entry (SKID=0) modes.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic srst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if sk ();
  pipe_stage_reg_if sg ();

  pipe_stage_reg #(.SKID(1)) dut_skid (
    .CLOCK(clk), .RESET(srst), .Flush_In(sk.flush), .Valid_In(sk.valid_up),
    .Ready_Out(sk.ready_up), .Ctrl_In(sk.ctrl_up), .Data_In(sk.data_up),
    .Valid_Out(sk.valid_dn), .Ready_In(sk.ready_dn), .Ctrl_Out(sk.ctrl_dn),
    .Data_Out(sk.data_dn), .Occupancy_Out(sk.occupancy)
  );

  pipe_stage_reg #(.SKID(0)) dut_single (
    .CLOCK(clk), .RESET(srst), .Flush_In(sg.flush), .Valid_In(sg.valid_up),
    .Ready_Out(sg.ready_up), .Ctrl_In(sg.ctrl_up), .Data_In(sg.data_up),
    .Valid_Out(sg.valid_dn), .Ready_In(sg.ready_dn), .Ctrl_Out(sg.ctrl_dn),
    .Data_Out(sg.data_dn), .Occupancy_Out(sg.occupancy)
  );

  // Inputs change and outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    sk.flush = 0; sk.valid_up = 0; sk.ctrl_up = '0; sk.data_up = '0; sk.ready_dn = 0;
    sg.flush = 0; sg.valid_up = 0; sg.ctrl_up = '0; sg.data_up = '0; sg.ready_dn = 0;
  endtask

  task automatic do_reset();
    srst = 1; step(); step(); srst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    total++; if (sk.valid_dn !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", sk.valid_dn); end
    total++; if (sk.ctrl_dn !== 8'h00) begin bad++; $display("FAIL reset_ctrl got=%h want=00", sk.ctrl_dn); end
    total++; if (sk.data_dn !== 128'h0) begin bad++; $display("FAIL reset_data got=%h want=0", sk.data_dn); end
    total++; if (sk.occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", sk.occupancy); end
    total++; if (sk.ready_up !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", sk.ready_up); end
    $display("txn reset: valid=%b occ=%0d ready=%b", sk.valid_dn, sk.occupancy, sk.ready_up);
  endtask

  task automatic test_streaming();
    sk.ready_dn = 1;
    for (int k = 1; k <= 4; k++) begin
      sk.valid_up = 1; sk.ctrl_up = 8'(k); sk.data_up = '0; sk.data_up[31:0] = k;
      step();
      total++; if (sk.valid_dn !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%b want=1", k, sk.valid_dn); end
      total++; if (sk.data_dn[31:0] !== 32'(k)) begin bad++; $display("FAIL stream_lane0_%0d got=%h want=%h", k, sk.data_dn[31:0], k); end
      total++; if (sk.occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ%0d got=%0d want=1", k, sk.occupancy); end
      $display("txn stream: lane0=%h occ=%0d", sk.data_dn[31:0], sk.occupancy);
    end
    sk.valid_up = 0;
    step();
    total++; if (sk.occupancy !== 2'd0) begin bad++; $display("FAIL stream_drain_occ got=%0d want=0", sk.occupancy); end
  endtask

  task automatic test_backpressure();
    sk.ready_dn = 0;
    sk.valid_up = 1; sk.ctrl_up = 8'h0A; sk.data_up = '0; sk.data_up[31:0] = 32'hA;
    step();
    sk.ctrl_up = 8'h0B; sk.data_up[31:0] = 32'hB;
    step();
    total++; if (sk.occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ_full got=%0d want=2", sk.occupancy); end
    total++; if (sk.ready_up !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", sk.ready_up); end
    total++; if (sk.data_dn[31:0] !== 32'hA) begin bad++; $display("FAIL bp_head got=%h want=a", sk.data_dn[31:0]); end
    $display("txn backpressure: occ=%0d head=%h", sk.occupancy, sk.data_dn[31:0]);
    sk.valid_up = 1; sk.data_up[31:0] = 32'hEE;  // refused while full
    step();
    total++; if (sk.data_dn[31:0] !== 32'hA) begin bad++; $display("FAIL bp_hold got=%h want=a", sk.data_dn[31:0]); end
    sk.valid_up = 0; sk.ready_dn = 1;
    step();
    total++; if (sk.data_dn[31:0] !== 32'hB || sk.valid_dn !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b want=b/1", sk.data_dn[31:0], sk.valid_dn); end
    total++; if (sk.ctrl_dn !== 8'h0B) begin bad++; $display("FAIL bp_second_ctrl got=%h want=0b", sk.ctrl_dn); end
    total++; if (sk.occupancy !== 2'd1) begin bad++; $display("FAIL bp_occ_one got=%0d want=1", sk.occupancy); end
    step();
    total++; if (sk.occupancy !== 2'd0 || sk.valid_dn !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0d/%b want=0/0", sk.occupancy, sk.valid_dn); end
  endtask

  task automatic test_flush();
    sk.ready_dn = 0;
    sk.valid_up = 1; sk.ctrl_up = 8'h01; sk.data_up = '0; sk.data_up[31:0] = 32'h1;
    step();
    sk.ctrl_up = 8'h02; sk.data_up[31:0] = 32'h2;
    step();
    sk.flush = 1; sk.ctrl_up = 8'h0C; sk.data_up[31:0] = 32'hC;
    step();
    sk.flush = 0; sk.valid_up = 0;
    total++; if (sk.valid_dn !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", sk.valid_dn); end
    total++; if (sk.ctrl_dn !== 8'h00) begin bad++; $display("FAIL flush_ctrl got=%h want=00", sk.ctrl_dn); end
    total++; if (sk.occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", sk.occupancy); end
    $display("txn flush: valid=%b occ=%0d", sk.valid_dn, sk.occupancy);
    sk.ready_dn = 1;
    step(); step(); step();
    total++; if (sk.valid_dn !== 1'b0) begin bad++; $display("FAIL flush_no_c got=%b/%h want=0", sk.valid_dn, sk.data_dn[31:0]); end
  endtask

  task automatic test_bubble();
    sk.ready_dn = 1;
    sk.valid_up = 1; sk.ctrl_up = 8'hFF; sk.data_up = '0; sk.data_up[31:0] = 32'h5;
    step();
    sk.valid_up = 0; sk.ctrl_up = '0;
    total++; if (sk.ctrl_dn !== 8'hFF) begin bad++; $display("FAIL bubble_ctrl_live got=%h want=ff", sk.ctrl_dn); end
    step();
    total++; if (sk.valid_dn !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%b want=0", sk.valid_dn); end
    total++; if (sk.ctrl_dn !== 8'h00) begin bad++; $display("FAIL bubble_ctrl got=%h want=00", sk.ctrl_dn); end
    total++; if (sk.data_dn[31:0] !== 32'h5) begin bad++; $display("FAIL bubble_data_hold got=%h want=5", sk.data_dn[31:0]); end
    $display("txn bubble: valid=%b ctrl=%h", sk.valid_dn, sk.ctrl_dn);
  endtask

  task automatic test_reset_two();
    sk.ready_dn = 0;
    sk.valid_up = 1; sk.ctrl_up = 8'h33; sk.data_up = '0; sk.data_up[31:0] = 32'h7;
    step(); step();
    total++; if (sk.occupancy !== 2'd2) begin bad++; $display("FAIL rst2_pre_occ got=%0d want=2", sk.occupancy); end
    sk.valid_up = 0;
    srst = 1; step(); srst = 0;
    total++; if (sk.valid_dn !== 1'b0 || sk.ctrl_dn !== 8'h00) begin bad++; $display("FAIL rst2_vc got=%b/%h want=0/00", sk.valid_dn, sk.ctrl_dn); end
    total++; if (sk.data_dn !== 128'h0) begin bad++; $display("FAIL rst2_data got=%h want=0", sk.data_dn); end
    total++; if (sk.occupancy !== 2'd0 || sk.ready_up !== 1'b1) begin bad++; $display("FAIL rst2_occ_rdy got=%0d/%b want=0/1", sk.occupancy, sk.ready_up); end
    sk.ready_dn = 1;
    step();
    total++; if (sk.valid_dn !== 1'b0) begin bad++; $display("FAIL rst2_no_skid got=%b want=0", sk.valid_dn); end
    $display("txn reset_two: valid=%b occ=%0d", sk.valid_dn, sk.occupancy);
  endtask

  task automatic test_single();
    sg.ready_dn = 0;
    sg.valid_up = 1; sg.ctrl_up = 8'h11; sg.data_up = '0; sg.data_up[31:0] = 32'h11;
    step();
    total++; if (sg.valid_dn !== 1'b1 || sg.occupancy !== 2'd1) begin bad++; $display("FAIL single_load got=%b/%0d want=1/1", sg.valid_dn, sg.occupancy); end
    #1;
    total++; if (sg.ready_up !== 1'b0) begin bad++; $display("FAIL single_ready_stall got=%b want=0", sg.ready_up); end
    sg.ctrl_up = 8'h22; sg.data_up[31:0] = 32'h22; sg.ready_dn = 1;
    #1;
    total++; if (sg.ready_up !== 1'b1) begin bad++; $display("FAIL single_ready_comb got=%b want=1", sg.ready_up); end
    step();
    total++; if (sg.data_dn[31:0] !== 32'h22 || sg.ctrl_dn !== 8'h22) begin bad++; $display("FAIL single_replace got=%h/%h want=22/22", sg.data_dn[31:0], sg.ctrl_dn); end
    $display("txn single: lane0=%h occ=%0d", sg.data_dn[31:0], sg.occupancy);
    sg.ready_dn = 0; sg.data_up[31:0] = 32'h44;
    step();
    total++; if (sg.occupancy !== 2'd1 || sg.data_dn[31:0] !== 32'h22) begin bad++; $display("FAIL single_cap got=%0d/%h want=1/22", sg.occupancy, sg.data_dn[31:0]); end
    sg.valid_up = 0; sg.ready_dn = 1;
    step();
    total++; if (sg.valid_dn !== 1'b0 || sg.occupancy !== 2'd0) begin bad++; $display("FAIL single_drain got=%b/%0d want=0/0", sg.valid_dn, sg.occupancy); end
  endtask

  initial begin
    srst = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_streaming();
    idle_inputs();
    test_backpressure();
    idle_inputs();
    test_flush();
    idle_inputs();
    test_bubble();
    idle_inputs();
    test_reset_two();
    idle_inputs();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 8, width of the control bundle (enables, selects, ALU op).
REQ-002 SHALL have parameter DATA_W, default 32, width of one data lane.
REQ-003 SHALL have parameter LANES, default 4, number of data lanes carried (operands, immediates, addresses).
REQ-004 SHALL have parameter SKID, default 1; 1 selects the two-entry skid mode, 0 selects the single-entry mode.
REQ-005 SHALL have the following ports:
- CLOCK  input  1  sole clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- Flush_In  input  1  discard all held entries (branch or hazard kill).
- Valid_In  input  1  upstream entry valid.
- Ready_Out  output  1  stage can accept an entry this cycle.
- Ctrl_In  input  CTRL_W  upstream control bundle.
- Data_In  input  LANES*DATA_W  upstream data lanes; lane k occupies bits [k*DATA_W +: DATA_W].
- Valid_Out  output  1  downstream entry valid.
- Ready_In  input  1  downstream can accept.
- Ctrl_Out  output  CTRL_W  control bundle to downstream.
- Data_Out  output  LANES*DATA_W  data lanes to downstream.
- Occupancy_Out  output  2  number of held entries (0..2).

Function
REQ-006 Accept SHALL occur when Valid_In=1 and Ready_Out=1; deliver SHALL occur when Valid_Out=1 and Ready_In=1.
REQ-007 Latency SHALL be 1 cycle: an entry accepted at edge N SHALL appear on Valid_Out/Ctrl_Out/Data_Out after edge N.
REQ-008 Entries SHALL leave in acceptance order; none SHALL be duplicated or lost except by Flush_In or RESET.
REQ-009 Ctrl_Out SHALL be all-zero whenever Valid_Out=0, so a bubble never asserts a downstream enable; Data_Out SHALL hold its last loaded value.
REQ-010 SKID=1 SHALL use FSM states EMPTY, ONE and TWO, held in a main slot plus a skid slot.
REQ-011 SKID=1: Ready_Out SHALL be 1 in EMPTY and ONE and 0 in TWO, driven from the state register only (no combinational path from Ready_In).
REQ-012 SKID=1 transitions:
- EMPTY + accept -> ONE.
- ONE + accept + no deliver -> TWO; the new entry goes to the skid slot.
- ONE + accept + deliver -> ONE; the main slot is replaced by the new entry.
- ONE + deliver only -> EMPTY.
- TWO + deliver -> ONE; the skid slot moves to the main slot.
- Otherwise the state holds.
REQ-013 SKID=1 SHALL sustain one entry per cycle while Ready_In=1 continuously.
REQ-014 SKID=0 SHALL hold one entry; Ready_Out = !Valid_Out || Ready_In (combinational); Occupancy_Out SHALL never exceed 1.
REQ-015 Flush_In=1 SHALL have priority over accept and deliver: after the edge, the state is EMPTY, Valid_Out=0 and Occupancy_Out=0, and any entry offered in the flush cycle is dropped.
REQ-016 The deliver indication in a flush cycle SHALL still be honoured by downstream; the stage SHALL NOT re-present the flushed entry.
REQ-017 Occupancy_Out SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO respectively.

Reset
REQ-018 RESET=1 at a rising edge SHALL force EMPTY, Valid_Out=0, Ctrl_Out=0, Data_Out=0 and Occupancy_Out=0; Ready_Out SHALL be 1 in the following cycle.
REQ-019 RESET SHALL take priority over Flush_In, accept and deliver; a mid-transfer reset discards both slots.

Structure
REQ-020 The shared package pipe_pkg SHALL hold the state enumeration (EMPTY/ONE/TWO) and the default values of CTRL_W, DATA_W and LANES.
REQ-021 A sub-module pipe_slot (one CTRL_W+LANES*DATA_W register with a load enable and a synchronous clear) SHALL be instantiated once for the main slot and, when SKID=1, once for the skid slot.

Verification
REQ-022 Streaming: SKID=1, Ready_In=1, Valid_In=1 with Data lane0 = 1,2,3,4 on consecutive cycles -> Valid_Out=1 with lane0 1,2,3,4 one cycle later each; Occupancy_Out=1 throughout.
REQ-023 Backpressure: SKID=1, accept 0xA then 0xB with Ready_In=0 -> Occupancy_Out=2, Ready_Out=0; raise Ready_In -> 0xA then 0xB are delivered in order, then Occupancy_Out=0.
REQ-024 Flush: state TWO plus Flush_In=1 with Valid_In=1 (Data 0xC) -> next cycle Valid_Out=0, Ctrl_Out=0, Occupancy_Out=0, and 0xC is never delivered.
REQ-025 Bubble: Ctrl_In=0xFF accepted and then delivered, with no new input -> the following cycle Valid_Out=0 and Ctrl_Out=0x00.
REQ-026 SKID=0: Valid_Out=1, Ready_In=0 -> Ready_Out=0; set Ready_In=1 in the same cycle -> Ready_Out=1 combinationally, and the new entry replaces the delivered one.
REQ-027 Reset: RESET=1 in state TWO -> next cycle all outputs 0 except Ready_Out=1.
